// File: rtl/key_load_unit_if.sv
// key_load_unit_if: serial key port plus parallel key bus of the key load unit.
//   key_start    one-cycle frame-start strobe
//   key_bit_vld  key_sdi valid this cycle
//   key_sdi      serial key bit (MSB first, then one even-parity bit)
//   key_out      parallel key to the lock stages
//   key_valid    key_out holds a parity-checked key
//   key_busy     frame in progress
//   key_err      one-cycle frame-failure pulse
//   locked_out   permanent lockout flag
//   fail_cnt     consecutive failed frames
// master: key source / observer side; slave: key_load_unit.
interface key_load_unit_if #(
  parameter int unsigned KEY_WIDTH = 16
);
  logic                 key_start;
  logic                 key_bit_vld;
  logic                 key_sdi;
  logic [KEY_WIDTH-1:0] key_out;
  logic                 key_valid;
  logic                 key_busy;
  logic                 key_err;
  logic                 locked_out;
  logic [7:0]           fail_cnt;

  modport master (
    output key_start, key_bit_vld, key_sdi,
    input  key_out, key_valid, key_busy, key_err, locked_out, fail_cnt
  );

  modport slave (
    input  key_start, key_bit_vld, key_sdi,
    output key_out, key_valid, key_busy, key_err, locked_out, fail_cnt
  );
endinterface

// File: rtl/key_load_unit.sv
// key_load_unit: deserialises the unlock key, checks even parity and an
// inter-bit timeout, and presents the key to the lock stages only after a
// good frame. Repeated failures latch a lockout cleared only by rst_n.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    key_load_unit_if.slave (serial key in, parallel key and status out)
module key_load_unit #(
  parameter int unsigned KEY_WIDTH = 16,
  parameter int unsigned MAX_FAIL  = 3,
  parameter int unsigned TIMEOUT   = 255
) (
  input logic            clk,
  input logic            rst_n,
  key_load_unit_if.slave bus
);
  localparam int unsigned BIT_W = $clog2(KEY_WIDTH + 1);
  localparam int unsigned TMO_W = 16;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, LOCKOUT} state_t;

  state_t               state;
  logic [KEY_WIDTH-1:0] shift_reg;
  logic [KEY_WIDTH-1:0] key_out_q;
  logic [BIT_W-1:0]     bit_cnt;
  logic [TMO_W-1:0]     tmo_cnt;
  logic [CNT_W-1:0]     fail_cnt_q;
  logic                 key_valid_q;
  logic                 key_busy_q;
  logic                 key_err_q;
  logic                 locked_q;

  logic                 tmo_hit_c;
  logic                 parity_bad_c;
  logic                 frame_fail_c;
  logic                 frame_pass_c;
  logic [CNT_W-1:0]     fail_next_c;

  // Idle cycle that would bring the timeout counter up to TIMEOUT.
  assign tmo_hit_c    = !bus.key_bit_vld && (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign parity_bad_c = ^{shift_reg, bus.key_sdi};
  assign frame_pass_c = (state == PARITY) && bus.key_bit_vld && !parity_bad_c;
  assign frame_fail_c = ((state == SHIFT) && tmo_hit_c) ||
                        ((state == PARITY) && (bus.key_bit_vld ? parity_bad_c : tmo_hit_c));
  assign fail_next_c  = fail_cnt_q + CNT_W'(1);

  // Frame FSM with all status outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shift_reg   <= '0;
      key_out_q   <= '0;
      bit_cnt     <= '0;
      tmo_cnt     <= '0;
      fail_cnt_q  <= '0;
      key_valid_q <= 1'b0;
      key_busy_q  <= 1'b0;
      key_err_q   <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      key_err_q <= 1'b0;
      unique case (state)
        IDLE: begin
          // Start wins over a coincident key_bit_vld; that bit is dropped.
          if (bus.key_start) begin
            state       <= SHIFT;
            key_busy_q  <= 1'b1;
            key_out_q   <= '0;
            key_valid_q <= 1'b0;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            tmo_cnt     <= '0;
          end
        end
        SHIFT: begin
          if (bus.key_bit_vld) begin
            shift_reg <= {shift_reg[KEY_WIDTH-2:0], bus.key_sdi};
            bit_cnt   <= bit_cnt + BIT_W'(1);
            tmo_cnt   <= '0;
            if (bit_cnt == BIT_W'(KEY_WIDTH - 1)) state <= PARITY;
          end else if (!tmo_hit_c) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        PARITY: begin
          if (!bus.key_bit_vld && !tmo_hit_c) tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
        LOCKOUT: begin
        end
      endcase

      // Frame completion overrides the per-state updates above.
      if (frame_pass_c) begin
        state       <= IDLE;
        key_busy_q  <= 1'b0;
        key_out_q   <= shift_reg;
        key_valid_q <= 1'b1;
        fail_cnt_q  <= '0;
      end
      if (frame_fail_c) begin
        key_busy_q <= 1'b0;
        key_err_q  <= 1'b1;
        fail_cnt_q <= fail_next_c;
        tmo_cnt    <= '0;
        if (fail_next_c == CNT_W'(MAX_FAIL)) begin
          state    <= LOCKOUT;
          locked_q <= 1'b1;
        end else begin
          state <= IDLE;
        end
      end
    end
  end

  assign bus.key_out    = key_out_q;
  assign bus.key_valid  = key_valid_q;
  assign bus.key_busy   = key_busy_q;
  assign bus.key_err    = key_err_q;
  assign bus.locked_out = locked_q;
  assign bus.fail_cnt   = fail_cnt_q;
endmodule

// File: doc/key_load_unit.md
Name: key_load_unit

Overview:
- Upstream feeder for the logic-locking stages: receives the unlock key serially from the external key port and drives the parallel key bus into every lock stage's key input.
- Validates each frame with even parity and an inter-bit timeout; key_out holds zero whenever no valid key is loaded, so downstream lock stages run obfuscated.
- Repeated bad frames latch a permanent lockout that only reset clears.

Parameters:
- KEY_WIDTH, 16, width of the key bus; must match the KEY_WIDTH of the lock stages it feeds.
- MAX_FAIL, 3, number of failed frames that triggers lockout (1..255).
- TIMEOUT, 255, maximum idle cycles between accepted bits inside a frame (1..65535).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key_start  input  1  one-cycle frame-start strobe.
- key_bit_vld  input  1  key_sdi is valid this cycle.
- key_sdi  input  1  serial key bit, MSB first, followed by one parity bit.
- key_out  output  KEY_WIDTH  parallel key to the lock stages.
- key_valid  output  1  key_out holds a parity-checked key.
- key_busy  output  1  a frame is in progress.
- key_err  output  1  one-cycle pulse on frame failure.
- locked_out  output  1  permanent lockout flag.
- fail_cnt  output  8  consecutive failed frames.

Behaviour:
- Reset (async, rst_n=0): state IDLE; key_out=0, key_valid=0, key_busy=0, key_err=0, locked_out=0, fail_cnt=0, shift register and bit/timeout counters=0.
- States: IDLE, SHIFT, PARITY, LOCKOUT. key_busy=1 in SHIFT and PARITY only.
- IDLE: key_start=1 -> SHIFT on the same edge; key_out<=0, key_valid<=0, bit counter and timeout counter cleared. key_bit_vld in IDLE is ignored, including in the key_start cycle (start wins).
- SHIFT: each key_bit_vld shifts key_sdi into the LSB of the shift register and increments the bit counter; the timeout counter clears. After KEY_WIDTH bits -> PARITY.
- PARITY: the first key_bit_vld samples the parity bit. Even parity: XOR of the KEY_WIDTH bits and the parity bit must equal 0.
  - Pass, on that same edge: key_out<=shift register, key_valid<=1, fail_cnt<=0, -> IDLE.
  - Fail: key_err<=1 for exactly one cycle, fail_cnt<=fail_cnt+1, key_out remains 0, -> IDLE, or -> LOCKOUT if the new fail_cnt==MAX_FAIL.
- Timeout: in SHIFT or PARITY, each cycle without key_bit_vld increments the timeout counter. Reaching TIMEOUT is handled exactly as a parity failure (err pulse, fail_cnt++, possible lockout).
- key_start while key_busy=1 is ignored. The frame continues unaffected.
- LOCKOUT: locked_out=1, key_out=0, key_valid=0. All inputs are ignored. Exit is by rst_n only. fail_cnt saturates at MAX_FAIL.
- Timing: key_out and key_valid are registered. key_out/key_valid are visible the cycle after the edge that samples the parity bit. key_out never shows partial shift contents.
- Reset mid-frame: immediate return to the reset values; the partial key is discarded.
- Reloading after a good key: key_start clears key_out and key_valid at once. Downstream stages are obfuscated until the new frame passes.

Test Plan:
- Good frame: start, bits 16'hACCF MSB first, parity 0 -> key_out=16'hACCF, key_valid=1 one cycle after the parity edge; key_err never asserts; fail_cnt=0.
- Bad parity: 16'hACCF with parity 1 -> single-cycle key_err, fail_cnt=1, key_out=0, key_valid=0, back in IDLE.
- Lockout: three consecutive bad frames (MAX_FAIL=3) -> locked_out=1 after the third; a following good frame is ignored and key_out stays 0; rst_n pulse returns locked_out=0 and fail_cnt=0.
- Timeout: start, 5 bits, then 255 idle cycles -> key_err pulse at the timeout, fail_cnt=1; a subsequent good frame gives key_valid=1 and fail_cnt=0.
- Corner events:
  - key_start together with key_bit_vld in IDLE -> that bit is not captured.
  - key_start mid-SHIFT -> ignored; the frame completes with the correct key.
- Async reset asserted between clock edges mid-frame -> all outputs 0 immediately, without waiting for a clock edge.
